// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32 pipeline stages.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold beats load; otherwise a bubble.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   hold,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= BUBBLE;
    end else if (flush) begin
      q <= BUBBLE;
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      q <= BUBBLE;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, fills IF/ID.
module if_fetch_stage #(
  parameter int unsigned          XLEN      = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  import rv_pkg::*;

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pc_pend, pend_n;
  logic [31:0]     skid, skid_n;
  logic            load;
  logic [31:0]     load_instr;
  logic            handshake;
  if_id_t          if_id_d, if_id_q;

  assign imem_req_valid = (state == S_REQ) && !redirect_valid && !reset;
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      pc_pend <= '0;
      skid    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pc_pend <= pend_n;
      skid    <= skid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_n     = pc_pend;
    skid_n     = skid;
    load       = 1'b0;
    load_instr = imem_rsp_data;
    if (redirect_valid) begin
      // Masking keeps every target bit read while clearing the low two.
      pc_n = redirect_target & ~XLEN'(3);
      unique case (state)
        S_WAIT, S_DROP: state_n = imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_n = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (handshake) begin
            pend_n  = pc;
            pc_n    = pc + XLEN'(4);
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (id_stall) begin
              skid_n  = imem_rsp_data;
              state_n = S_HOLD;
            end else begin
              load    = 1'b1;
              state_n = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            load       = 1'b1;
            load_instr = skid;
            state_n    = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_n = S_REQ;
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  assign if_id_d = '{valid: 1'b1, pc: pc_pend, instr: load_instr};

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .hold  (id_stall),
    .load  (load),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;

endmodule
